// File: rtl/snake_pkg.sv
// Shared encodings, board limits and defaults for the snake game blocks.
package snake_pkg;

   typedef enum logic [1:0] {
      ST_RESTART = 2'b00,
      ST_START   = 2'b01,
      ST_PLAY    = 2'b10,
      ST_DIE     = 2'b11
   } game_status_e;

   localparam logic [5:0] X_MIN       = 6'd1;
   localparam logic [5:0] X_MAX       = 6'd38;
   localparam logic [5:0] Y_MIN       = 6'd1;
   localparam logic [5:0] Y_MAX       = 6'd28;
   localparam logic [5:0] APPLE_X_DEF = 6'd24;
   localparam logic [5:0] APPLE_Y_DEF = 6'd10;

   localparam int MAX_CUBES_DEF = 16;

   function automatic logic on_board(input logic [5:0] x, input logic [5:0] y);
      return (x >= X_MIN) && (x <= X_MAX) && (y >= Y_MIN) && (y <= Y_MAX);
   endfunction

endpackage

// File: rtl/snake_game_ctrl_if.sv
// Signals between the game sequencer and the keys/datapath/renderer.
interface snake_game_ctrl_if;
   logic       start_press;
   logic       hit_wall;
   logic       hit_body;
   logic [5:0] head_x;
   logic [5:0] head_y;
   logic [6:0] cube_num;
   logic [1:0] game_status;
   logic       die_flash;
   logic       add_cube;
   logic [5:0] apple_x;
   logic [5:0] apple_y;

   // master is the sequencer itself
   modport master (
      input  start_press, hit_wall, hit_body, head_x, head_y, cube_num,
      output game_status, die_flash, add_cube, apple_x, apple_y
   );

   modport slave (
      output start_press, hit_wall, hit_body, head_x, head_y, cube_num,
      input  game_status, die_flash, add_cube, apple_x, apple_y
   );
endinterface

// File: rtl/snake_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) used for apple placement.
module snake_lfsr16 (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] q
);

   localparam logic [15:0] SEED = 16'hACE1;

   logic [15:0] q_d;
   logic [15:0] q_q;

   always_comb begin
      q_d = {q_q[14:0], q_q[15] ^ q_q[13] ^ q_q[12] ^ q_q[10]};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) q_q <= SEED;
      else      q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: status FSM, death blink, apple eating and relocation.
module snake_game_ctrl
   import snake_pkg::*;
#(
   parameter int FLASH_CYCLES  = 12_500_000,
   parameter int FLASH_TOGGLES = 8,
   parameter int MAX_CUBES     = MAX_CUBES_DEF
) (
   input  logic                clk,
   input  logic                rst,
   snake_game_ctrl_if.master   bus
);

   localparam int FW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
   localparam int TW = $clog2(FLASH_TOGGLES + 1);

   game_status_e  state_q, state_d;
   logic [FW-1:0] flash_cnt_q, flash_cnt_d;
   logic [TW-1:0] tog_cnt_q, tog_cnt_d;
   logic          die_flash_q, die_flash_d;
   logic          add_cube_q, add_cube_d;
   logic [5:0]    apple_x_q, apple_x_d;
   logic [5:0]    apple_y_q, apple_y_d;
   logic          apple_ok_q, apple_ok_d;

   logic [15:0]   lfsr;
   logic [5:0]    cand_x;
   logic [5:0]    cand_y;
   logic          cand_ok;
   logic          collide;
   logic          full;
   logic          eat;
   logic          flash_wrap;
   logic          lfsr_unused;

   snake_lfsr16 u_lfsr (
      .clk (clk),
      .rst (rst),
      .q   (lfsr)
   );

   // y candidate keeps only 5 bits so it spans 0..31
   assign cand_x      = lfsr[5:0];
   assign cand_y      = {1'b0, lfsr[12:8]};
   assign lfsr_unused = ^{lfsr[15:13], lfsr[7:6]};
   assign cand_ok     = on_board(cand_x, cand_y) &&
                        !((cand_x == bus.head_x) && (cand_y == bus.head_y));

   assign collide    = bus.hit_wall | bus.hit_body;
   assign full       = (bus.cube_num >= 7'(MAX_CUBES));
   assign eat        = apple_ok_q && (bus.head_x == apple_x_q) && (bus.head_y == apple_y_q);
   assign flash_wrap = (flash_cnt_q == FW'(FLASH_CYCLES - 1));

   always_comb begin
      state_d     = state_q;
      flash_cnt_d = '0;
      tog_cnt_d   = '0;
      die_flash_d = 1'b1;
      add_cube_d  = 1'b0;
      apple_x_d   = apple_x_q;
      apple_y_d   = apple_y_q;
      apple_ok_d  = apple_ok_q;

      if (!apple_ok_q && cand_ok) begin
         apple_x_d  = cand_x;
         apple_y_d  = cand_y;
         apple_ok_d = 1'b1;
      end

      case (state_q)
         ST_RESTART: begin
            state_d    = ST_START;
            apple_x_d  = APPLE_X_DEF;
            apple_y_d  = APPLE_Y_DEF;
            apple_ok_d = 1'b1;
         end
         ST_START: begin
            if (bus.start_press) state_d = ST_PLAY;
         end
         ST_PLAY: begin
            // a collision on the apple square kills without growing
            if (collide || full) begin
               state_d = ST_DIE;
            end else if (eat) begin
               add_cube_d = 1'b1;
               apple_ok_d = 1'b0;
            end
         end
         ST_DIE: begin
            die_flash_d = die_flash_q;
            tog_cnt_d   = tog_cnt_q;
            if (flash_wrap) begin
               if (tog_cnt_q == TW'(FLASH_TOGGLES)) begin
                  state_d     = ST_RESTART;
                  die_flash_d = 1'b1;
                  tog_cnt_d   = '0;
               end else begin
                  die_flash_d = ~die_flash_q;
                  tog_cnt_d   = tog_cnt_q + TW'(1);
               end
            end else begin
               flash_cnt_d = flash_cnt_q + FW'(1);
            end
         end
         default: state_d = ST_RESTART;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_RESTART;
         flash_cnt_q <= '0;
         tog_cnt_q   <= '0;
         die_flash_q <= 1'b1;
         add_cube_q  <= 1'b0;
         apple_x_q   <= APPLE_X_DEF;
         apple_y_q   <= APPLE_Y_DEF;
         apple_ok_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         flash_cnt_q <= flash_cnt_d;
         tog_cnt_q   <= tog_cnt_d;
         die_flash_q <= die_flash_d;
         add_cube_q  <= add_cube_d;
         apple_x_q   <= apple_x_d;
         apple_y_q   <= apple_y_d;
         apple_ok_q  <= apple_ok_d;
      end
   end

   assign bus.game_status = state_q;
   assign bus.die_flash   = die_flash_q;
   assign bus.add_cube    = add_cube_q;
   assign bus.apple_x     = apple_x_q;
   assign bus.apple_y     = apple_y_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl with short flash timing.
module tb_snake_game_ctrl;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errs;

   logic [15:0] m_lfsr;
   logic [5:0]  ax;
   logic [5:0]  ay;

   snake_game_ctrl_if bus ();

   snake_game_ctrl #(
      .FLASH_CYCLES  (4),
      .FLASH_TOGGLES (8),
      .MAX_CUBES     (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference sequence: 16-bit Fibonacci, taps 16,14,13,11, seed ACE1
   always @(posedge clk or negedge rst) begin
      if (!rst) m_lfsr <= 16'hACE1;
      else      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
   end

   task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic cand_good(input logic [15:0] l, input logic [5:0] hx, input logic [5:0] hy);
      logic [5:0] x;
      logic [5:0] y;
      x = l[5:0];
      y = {1'b0, l[12:8]};
      return (x >= 6'd1) && (x <= 6'd38) && (y >= 6'd1) && (y <= 6'd28) && !((x == hx) && (y == hy));
   endfunction

   // entered at the falling edge where add_cube is first seen high
   task automatic reloc_check(input string tag, input logic [5:0] hx, input logic [5:0] hy);
      logic       found;
      int         n;
      logic [5:0] ex;
      logic [5:0] ey;
      found = 1'b0;
      n     = 0;
      ex    = '0;
      ey    = '0;
      while (!found && n < 200) begin
         if (cand_good(m_lfsr, hx, hy)) begin
            ex    = m_lfsr[5:0];
            ey    = {1'b0, m_lfsr[12:8]};
            found = 1'b1;
         end
         @(negedge clk);
         if (n == 0) chk({tag, "_pulse_end"}, 16'(bus.add_cube), 16'd0);
         n++;
      end
      chk({tag, "_bounded"}, 16'(found), 16'd1);
      chk({tag, "_apple_x"}, 16'(bus.apple_x), 16'(ex));
      chk({tag, "_apple_y"}, 16'(bus.apple_y), 16'(ey));
      chk({tag, "_on_board"}, 16'((bus.apple_x >= 6'd1) && (bus.apple_x <= 6'd38) &&
                                  (bus.apple_y >= 6'd1) && (bus.apple_y <= 6'd28)), 16'd1);
      chk({tag, "_not_head"}, 16'((bus.apple_x == hx) && (bus.apple_y == hy)), 16'd0);
      ax = ex;
      ay = ey;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_status"},  16'(bus.game_status), 16'd0);
      chk({tag, "_flash"},   16'(bus.die_flash),   16'd1);
      chk({tag, "_add"},     16'(bus.add_cube),    16'd0);
      chk({tag, "_apple_x"}, 16'(bus.apple_x),     16'd24);
      chk({tag, "_apple_y"}, 16'(bus.apple_y),     16'd10);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks        = 0;
      n_errs          = 0;
      ax              = '0;
      ay              = '0;
      rst             = 1'b0;
      bus.start_press = 1'b0;
      bus.hit_wall    = 1'b0;
      bus.hit_body    = 1'b0;
      bus.head_x      = 6'd1;
      bus.head_y      = 6'd1;
      bus.cube_num    = 7'd3;

      repeat (3) @(negedge clk);
      chk_reset_vals("reset");

      rst = 1'b1;
      #1 chk("status_at_release", 16'(bus.game_status), 16'd0);
      @(negedge clk);
      chk("status_start", 16'(bus.game_status), 16'd1);

      bus.hit_wall = 1'b1;
      bus.hit_body = 1'b1;
      repeat (2) @(negedge clk);
      chk("start_ignores_hit", 16'(bus.game_status), 16'd1);
      bus.hit_wall = 1'b0;
      bus.hit_body = 1'b0;

      bus.start_press = 1'b1;
      @(negedge clk);
      bus.start_press = 1'b0;
      chk("status_play", 16'(bus.game_status), 16'd2);

      // first eat on the default apple
      bus.head_x = 6'd24;
      bus.head_y = 6'd10;
      @(negedge clk);
      chk("eat1_add", 16'(bus.add_cube), 16'd1);
      reloc_check("reloc1", 6'd24, 6'd10);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("eat1_no_repeat", 16'(bus.add_cube), 16'd0);
      end

      // second eat on the relocated apple
      bus.head_x = ax;
      bus.head_y = ay;
      @(negedge clk);
      chk("eat2_add", 16'(bus.add_cube), 16'd1);
      reloc_check("reloc2", bus.head_x, bus.head_y);

      // wall hit while on the apple
      bus.head_x   = ax;
      bus.head_y   = ay;
      bus.hit_wall = 1'b1;
      @(negedge clk);
      bus.hit_wall = 1'b0;
      chk("hit_status_die", 16'(bus.game_status), 16'd3);
      chk("hit_no_add", 16'(bus.add_cube), 16'd0);
      chk("die_entry_flash", 16'(bus.die_flash), 16'd1);

      for (int t = 1; t <= 36; t++) begin
         @(negedge clk);
         if (t < 36) begin
            chk("die_status", 16'(bus.game_status), 16'd3);
            chk("die_flash", 16'(bus.die_flash), (((t / 4) % 2) == 0) ? 16'd1 : 16'd0);
         end else begin
            chk("restart_status", 16'(bus.game_status), 16'd0);
            chk("restart_flash", 16'(bus.die_flash), 16'd1);
         end
      end
      @(negedge clk);
      chk("after_restart_status", 16'(bus.game_status), 16'd1);
      chk("after_restart_flash", 16'(bus.die_flash), 16'd1);
      chk("after_restart_apple_x", 16'(bus.apple_x), 16'd24);
      chk("after_restart_apple_y", 16'(bus.apple_y), 16'd10);

      // second game: eat, then fill up
      bus.head_x      = 6'd5;
      bus.head_y      = 6'd5;
      bus.start_press = 1'b1;
      @(negedge clk);
      bus.start_press = 1'b0;
      chk("game2_play", 16'(bus.game_status), 16'd2);
      bus.head_x = 6'd24;
      bus.head_y = 6'd10;
      @(negedge clk);
      chk("eat3_add", 16'(bus.add_cube), 16'd1);
      reloc_check("reloc3", 6'd24, 6'd10);

      bus.cube_num = 7'd16;
      @(negedge clk);
      chk("full_status_die", 16'(bus.game_status), 16'd3);
      repeat (5) @(negedge clk);
      chk("full_mid_flash", 16'(bus.die_flash), 16'd0);

      #2 rst = 1'b0;
      #1 chk_reset_vals("async_reset");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule

// File: doc/snake_game_ctrl.md
# snake_game_ctrl

Top-level sequencer for the snake game. It owns the game-status state machine that drives the snake datapath's `game_status` input. It also detects apple eating, issues the `add_cube` grow request, relocates the apple with a pseudo-random generator, and produces the `die_flash` blink after a collision. It sits between the debounced key inputs, the snake datapath and the VGA renderer.

## Interface
- `FLASH_CYCLES`, default 12_500_000: clk cycles per `die_flash` half-period.
- `FLASH_TOGGLES`, default 8: number of `die_flash` toggles in DIE before restarting.
- `MAX_CUBES`, default 16: snake capacity; reaching it ends the game.
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, asynchronous, active-low.
- `start_press`, in, 1: single-cycle debounced key pulse (any direction key).
- `hit_wall`, in, 1: collision flag from the datapath, level.
- `hit_body`, in, 1: collision flag from the datapath, level.
- `head_x`, in, 6: head column, legal range 1..38.
- `head_y`, in, 6: head row, legal range 1..28.
- `cube_num`, in, 7: current snake length.
- `game_status`, out, 2: RESTART=00, START=01, PLAY=10, DIE=11.
- `die_flash`, out, 1: 1 shows the snake, 0 blanks it.
- `add_cube`, out, 1: grow request, one-cycle pulse.
- `apple_x`, out, 6: apple column.
- `apple_y`, out, 6: apple row.

## Operation
- **FSM states:** RESTART → START → PLAY → DIE → RESTART.
- **RESTART:** lasts exactly one cycle, then goes to START. The datapath reinitialises on this status.
- **START:** holds until `start_press`=1, then goes to PLAY on the next edge.
- **PLAY:**
  - Goes to DIE when `hit_wall|hit_body`=1.
  - Also goes to DIE when `cube_num` ≥ `MAX_CUBES`.
  - Collision has priority over eating in the same cycle; no `add_cube` is issued then.
- **DIE:**
  - `flash_cnt` counts 0..`FLASH_CYCLES`-1. On wrap, `die_flash` toggles and `tog_cnt` increments.
  - When `tog_cnt` = `FLASH_TOGGLES` at a wrap, the FSM goes to RESTART and `die_flash` is forced to 1.
  - Both counters clear on entry to DIE.
- **`die_flash`:** held at 1 in every state except DIE.
- **Eat detection:**
  - In PLAY, with `apple_ok`=1 and `head_x`==`apple_x` and `head_y`==`apple_y`: assert `add_cube` for one cycle and clear `apple_ok`.
  - Eating is not re-detected while `apple_ok`=0.
- **Apple relocation (rejection sampling):**
  - While `apple_ok`=0, each cycle takes candidate x = `lfsr[5:0]`, y = `lfsr[13:8]` (upper bits masked to 5 bits, giving 0..31).
  - The candidate is accepted if 1≤x≤38, 1≤y≤28 and (x,y)≠(`head_x`,`head_y`).
  - On accept: load `apple_x`/`apple_y` and set `apple_ok`=1. Otherwise retry on the next cycle.
  - Overlap with body cubes other than the head is permitted.
- **LFSR:**
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Seed 16'hACE1 on reset; free-runs every cycle in every state; never all-zero.
- **RESTART effect on the apple:** sets the apple to (24,10) and `apple_ok`=1.

## Timing
- **Reset values:** `game_status`=RESTART, `die_flash`=1, `add_cube`=0, `apple_x`=24, `apple_y`=10, `apple_ok`=1, all counters 0.
- **Registered outputs:** all outputs are registered.
  - `game_status` changes one edge after the triggering input is sampled.
  - `add_cube` rises one edge after the head/apple match is sampled, and is high for exactly one cycle.
- **Relocation latency:** ≥1 cycle after `add_cube`. Worst case is bounded by the LFSR period; typical is under 8 cycles, which is far below one move tick.
- **Reset mid-operation:** asynchronous assertion immediately returns all registers to their reset values, including mid-DIE and mid-relocation.
- **`start_press` outside START:** ignored.
- **Collision asserted in START:** ignored.

## Structure
- **Shared package `snake_pkg`:**
  - Status encodings RESTART/START/PLAY/DIE.
  - Board bounds X_MIN=1, X_MAX=38, Y_MIN=1, Y_MAX=28.
  - Default apple position (24,10).
  - MAX_CUBES.
- **Sub-module `snake_lfsr16`:** ports `clk`, `rst`, output `q`[15:0]; seed and taps are internal.
- **Remaining logic in this module:** FSM, flash counters, eat/relocate logic.

## Test plan
- Reset, then `start_press` pulse → `game_status` goes 00→01 one cycle after reset release, then 10 one edge after the pulse.
- PLAY, drive head=(24,10) → `add_cube`=1 for exactly one cycle. The new apple is within 1..38 × 1..28 and ≠ (24,10). Holding the head there issues no second `add_cube`.
- PLAY, assert `hit_wall` together with the head on the apple → DIE next edge, `add_cube` stays 0.
- DIE with `FLASH_CYCLES`=4, `FLASH_TOGGLES`=8 → `die_flash` toggles every 4 cycles, 8 toggles, then RESTART for one cycle with `die_flash`=1, then START.
- PLAY, drive `cube_num`=16 → DIE next edge. Also, `rst` low mid-DIE → all outputs at reset values in the same cycle, asynchronously.
